// File: rtl/bcd_decrementor.sv
// bcd_decrementor: multi-digit packed-BCD down-counter.
//
// A preset is loaded into the count. `start` arms counting from IDLE. Each
// `tick` in RUN then removes one unit from the least significant digit, with a
// decimal borrow into the higher digits. `done` pulses on the edge that writes
// zero into the count.
//
// Control inputs:
//   `load`, `start` and `tick` are level-sampled single-cycle qualifiers. There
//   is no ready/acknowledge: every rising edge on which an input is high
//   consumes it. When several are high in the same cycle, the priority is
//   load > start > tick. `start` has no effect in RUN, so a tick that arrives
//   together with `start` in RUN still decrements.
//
// Invariant: the count register only ever holds valid BCD. An invalid preset
// is replaced by zero and flagged on `err`.
module bcd_decrementor #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  start,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [0:0]            state
);

  localparam int W = 4 * DIGITS;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         err_q, err_d;
  logic         done_q, done_d;

  logic         in_valid;
  logic [W-1:0] dec_value;
  logic         borrow;
  logic         count_is_zero;
  logic         dec_is_zero;

  // Preset check: every nibble of bcd_in must be a decimal digit.
  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        in_valid = 1'b0;
      end
    end
  end

  // Combinational borrow chain. A zero count rolls to all-nines, which gives
  // the wrap value without any extra logic.
  always_comb begin
    borrow    = 1'b1;
    dec_value = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_value[4*i +: 4] = 4'd9;
        end else begin
          dec_value[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_is_zero = (count_q == '0);
  assign dec_is_zero   = (dec_value == '0);

  // Next-state logic: load overrides everything, start matters only in IDLE,
  // and tick matters only in RUN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      if (in_valid) begin
        count_d = bcd_in;
        err_d   = 1'b0;
      end else begin
        count_d = '0;
        err_d   = 1'b1;
      end
    end else if (state_q == ST_IDLE) begin
      if (start && !err_q) begin
        if (count_is_zero) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else if (tick) begin
      if (count_is_zero) begin
        // Only reachable with WRAP=1. A zero seen in RUN without wrap is
        // treated as a finished count.
        if (WRAP) begin
          count_d = dec_value;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        count_d = dec_value;
        if (dec_is_zero) begin
          done_d = 1'b1;
          if (!WRAP) begin
            state_d = ST_IDLE;
          end
        end
      end
    end
  end

  // State, count and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out = count_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_bcd_decrementor.sv
// tb_bcd_decrementor: drives a WRAP=0 and a WRAP=1 instance from shared
// stimulus. A decimal-integer model of each counter predicts the outputs.
// Directed steps pin known values, and a random phase follows.
module tb_bcd_decrementor;

  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
  localparam int W      = BW + 3;
  localparam int MAXV   = 999;

  logic          clk;
  logic          reset_n;
  logic          load;
  logic [BW-1:0] bcd_in;
  logic          start;
  logic          tick;

  logic [BW-1:0] bcd_out0, bcd_out1;
  logic          busy0, busy1, done0, done1, err0, err1;
  logic [0:0]    state0, state1;

  int errors = 0;
  int checks = 0;

  // Model state per instance: index 0 is WRAP=0, index 1 is WRAP=1.
  int m_val  [2];
  bit m_run  [2];
  bit m_err  [2];
  bit m_done [2];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  bcd_decrementor #(.DIGITS(DIGITS), .WRAP(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in),
    .start(start), .tick(tick), .bcd_out(bcd_out0), .busy(busy0),
    .done(done0), .err(err0), .state(state0)
  );

  bcd_decrementor #(.DIGITS(DIGITS), .WRAP(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in),
    .start(start), .tick(tick), .bcd_out(bcd_out1), .busy(busy1),
    .done(done1), .err(err1), .state(state1)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] int2bcd(input int v);
    logic [BW-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [BW-1:0] b);
    int s;
    int p;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s = s + int'(b[4*i +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic bit all_valid(input logic [BW-1:0] b);
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(b[4*i +: 4]) > 9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] pack_exp(input int k);
    return {int2bcd(m_val[k]), m_run[k], m_done[k], m_err[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. The count is a plain decimal integer, and each
  // rising edge pushes the predicted output vector for the compare process.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_val[k] = 0; m_run[k] = 0; m_err[k] = 0; m_done[k] = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] = 0;
        if (load) begin
          m_run[k] = 0;
          if (all_valid(bcd_in)) begin
            m_val[k] = bcd2int(bcd_in);
            m_err[k] = 0;
          end else begin
            m_val[k] = 0;
            m_err[k] = 1;
          end
        end else if (!m_run[k]) begin
          if (start && !m_err[k]) begin
            if (m_val[k] == 0) m_done[k] = 1;
            else m_run[k] = 1;
          end
        end else if (tick) begin
          if (m_val[k] == 0) begin
            if (k == 1) m_val[k] = MAXV;
            else m_run[k] = 0;
          end else begin
            m_val[k] = m_val[k] - 1;
            if (m_val[k] == 0) begin
              m_done[k] = 1;
              if (k == 0) m_run[k] = 0;
            end
          end
        end
      end
      exp_q0.push_back(pack_exp(0));
      exp_q1.push_back(pack_exp(1));
    end
  end

  // Scoreboard compare on the falling edge. An empty queue means no rising
  // edge has occurred since reset, so the reset values are expected.
  always @(negedge clk) begin
    logic [W-1:0] e0, e1;
    if (!reset_n || exp_q0.size() == 0) e0 = '0;
    else e0 = exp_q0.pop_front();
    if (!reset_n || exp_q1.size() == 0) e1 = '0;
    else e1 = exp_q1.pop_front();
    check("cmp_wrap0", 32'({bcd_out0, busy0, done0, err0}), 32'(e0));
    check("cmp_wrap1", 32'({bcd_out1, busy1, done1, err1}), 32'(e1));
  end

  // Driver: present inputs for one rising edge, then observe 1 ns after it.
  task automatic step(input logic l, input logic [BW-1:0] b, input logic s, input logic t);
    load   = l;
    bcd_in = b;
    start  = s;
    tick   = t;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    tick  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    load    = 1'b0;
    bcd_in  = '0;
    start   = 1'b0;
    tick    = 1'b0;
    #1 reset_n = 1'b0;
    #11;
    check("reset_bcd", 32'(bcd_out0), 32'h0);
    check("reset_flags", 32'({busy0, done0, err0}), 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Countdown 025 to 000.
    step(1'b1, 12'h025, 1'b0, 1'b0);
    check("load_025", 32'(bcd_out0), 32'h025);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    check("start_busy", 32'(busy0), 32'h1);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 12'h000, 1'b0, 1'b1);
      check("cd_value", 32'(bcd_out0), 32'(int2bcd(24 - i)));
      check("cd_done", 32'(done0), (i == 24) ? 32'h1 : 32'h0);
      check("cd_busy", 32'(busy0), (i == 24) ? 32'h0 : 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 12'h000, 1'b0, 1'b1);
      check("cd_hold", 32'({bcd_out0, done0}), 32'h0);
    end

    // Borrow chains.
    step(1'b1, 12'h100, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("borrow_100", 32'(bcd_out0), 32'h099);
    step(1'b1, 12'h010, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("borrow_010", 32'(bcd_out0), 32'h009);
    step(1'b1, 12'h901, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("borrow_901a", 32'(bcd_out0), 32'h900);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("borrow_901b", 32'(bcd_out0), 32'h899);

    // Invalid preset.
    step(1'b1, 12'h0A5, 1'b0, 1'b0);
    check("inv_err", 32'(err0), 32'h1);
    check("inv_bcd", 32'(bcd_out0), 32'h000);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    check("inv_start", 32'({busy0, done0}), 32'h0);
    step(1'b1, 12'h042, 1'b0, 1'b0);
    check("reload_err", 32'(err0), 32'h0);
    check("reload_bcd", 32'(bcd_out0), 32'h042);

    // Wrap through zero (WRAP=1 instance).
    step(1'b1, 12'h001, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("wrap_zero", 32'({bcd_out1, busy1, done1}), 32'({12'h000, 1'b1, 1'b1}));
    check("nowrap_zero", 32'({bcd_out0, busy0, done0}), 32'({12'h000, 1'b0, 1'b1}));
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("wrap_999", 32'({bcd_out1, done1}), 32'({12'h999, 1'b0}));
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("wrap_998", 32'(bcd_out1), 32'h998);

    // Abort with load and tick together.
    step(1'b1, 12'h050, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 1'b1);
    check("abort_047", 32'(bcd_out0), 32'h047);
    step(1'b1, 12'h120, 1'b0, 1'b1);
    check("abort_load", 32'({bcd_out0, busy0}), 32'({12'h120, 1'b0}));
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("idle_tick", 32'(bcd_out0), 32'h120);

    // Start on a zero count.
    step(1'b1, 12'h000, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    check("zero_start", 32'({busy0, done0}), 32'h1);
    step(1'b0, 12'h000, 1'b0, 1'b0);
    check("zero_pulse", 32'(done0), 32'h0);

    // Asynchronous reset mid-count.
    step(1'b1, 12'h300, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b0, 1'b1);
    check("pre_reset", 32'(bcd_out0), 32'h295);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 32'({bcd_out0, busy0, done0, err0}), 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1'b0, 12'h000, 1'b0, 1'b1);
    check("post_reset", 32'({bcd_out0, busy0}), 32'h0);

    // Random phase; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic          l, s, t;
      logic [BW-1:0] b;
      l = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: b = BW'($urandom);
        1: b = int2bcd($urandom_range(0, MAXV));
        default: b = int2bcd($urandom_range(0, 20));
      endcase
      step(l, b, s, t);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
